// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for a single APB master: accepts one
// command, drives the master until done/error/timeout, then pulses a response.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRST,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ack,
    output logic [1:0]  resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic        transfer,
    output logic        RD_WR,
    output logic [8:0]  apb_wr_padd,
    output logic [8:0]  apb_rd_padd,
    output logic [7:0]  apb_wr_data,
    input  logic        xfer_done,
    input  logic [7:0]  apb_rd_data_out,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        rr_ptr_q;
    logic        gnt_q;
    logic [7:0]  tcnt_q;
    logic        transfer_q;
    logic        rd_wr_q;
    logic [8:0]  wr_padd_q;
    logic [8:0]  rd_padd_q;
    logic [7:0]  wr_data_q;
    logic [1:0]  resp_valid_q;
    logic [7:0]  resp_rdata_q;
    logic        resp_err_q;
    logic        resp_timeout_q;

    logic        in_idle;
    logic        any_valid;
    logic        grant_d;
    logic [8:0]  addr_sel;
    logic [7:0]  wdata_sel;
    logic        write_sel;

    // The unused encoding 2'b11 behaves exactly like IDLE.
    assign in_idle   = (state_q != BUSY) && (state_q != RESP);
    assign any_valid = |req_valid;
    assign grant_d   = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    assign addr_sel  = grant_d ? req_addr[17:9]  : req_addr[8:0];
    assign wdata_sel = grant_d ? req_wdata[15:8] : req_wdata[7:0];
    assign write_sel = req_write[grant_d];

    assign req_ack = (PRST && in_idle && any_valid) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge PCLK) begin
        if (!PRST) begin
            state_q        <= IDLE;
            rr_ptr_q       <= 1'b0;
            gnt_q          <= 1'b0;
            tcnt_q         <= 8'd0;
            transfer_q     <= 1'b0;
            rd_wr_q        <= 1'b0;
            wr_padd_q      <= 9'd0;
            rd_padd_q      <= 9'd0;
            wr_data_q      <= 8'd0;
            resp_valid_q   <= 2'b00;
            resp_rdata_q   <= 8'd0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else if (in_idle) begin
            state_q    <= IDLE;
            transfer_q <= 1'b0;
            if (any_valid) begin
                state_q    <= BUSY;
                gnt_q      <= grant_d;
                tcnt_q     <= 8'd0;
                transfer_q <= 1'b1;
                rd_wr_q    <= ~write_sel;
                if (write_sel) begin
                    wr_padd_q <= addr_sel;
                    wr_data_q <= wdata_sel;
                    rd_padd_q <= 9'd0;
                end else begin
                    rd_padd_q <= addr_sel;
                    wr_padd_q <= 9'd0;
                    wr_data_q <= 8'd0;
                end
            end
        end else if (state_q == BUSY) begin
            tcnt_q <= tcnt_q + 8'd1;
            // Error beats completion, completion beats timeout.
            if (PSLVERR) begin
                state_q        <= RESP;
                transfer_q     <= 1'b0;
                resp_valid_q   <= gnt_q ? 2'b10 : 2'b01;
                resp_err_q     <= 1'b1;
                resp_timeout_q <= 1'b0;
                resp_rdata_q   <= 8'd0;
            end else if (xfer_done) begin
                state_q        <= RESP;
                transfer_q     <= 1'b0;
                resp_valid_q   <= gnt_q ? 2'b10 : 2'b01;
                resp_err_q     <= 1'b0;
                resp_timeout_q <= 1'b0;
                resp_rdata_q   <= rd_wr_q ? apb_rd_data_out : 8'd0;
            end else if (tcnt_q == TCNT_LAST) begin
                state_q        <= RESP;
                transfer_q     <= 1'b0;
                resp_valid_q   <= gnt_q ? 2'b10 : 2'b01;
                resp_err_q     <= 1'b1;
                resp_timeout_q <= 1'b1;
                resp_rdata_q   <= 8'd0;
            end
        end else begin
            state_q        <= IDLE;
            rr_ptr_q       <= ~gnt_q;
            resp_valid_q   <= 2'b00;
            resp_rdata_q   <= 8'd0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end
    end

    assign transfer     = transfer_q;
    assign RD_WR        = rd_wr_q;
    assign apb_wr_padd  = wr_padd_q;
    assign apb_rd_padd  = rd_padd_q;
    assign apb_wr_data  = wr_data_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: each task drives one scenario and
// checks outputs at the falling edge against hand-computed values.
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRST = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_write = 2'b00;
    logic [17:0] req_addr = 18'd0;
    logic [15:0] req_wdata = 16'd0;
    logic [1:0]  req_ack;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic        resp_timeout;
    logic        transfer;
    logic        RD_WR;
    logic [8:0]  apb_wr_padd;
    logic [8:0]  apb_rd_padd;
    logic [7:0]  apb_wr_data;
    logic        xfer_done = 1'b0;
    logic [7:0]  apb_rd_data_out = 8'd0;
    logic        PSLVERR = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    apb_req_arbiter #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRST(PRST),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_timeout(resp_timeout), .transfer(transfer),
        .RD_WR(RD_WR), .apb_wr_padd(apb_wr_padd),
        .apb_rd_padd(apb_rd_padd), .apb_wr_data(apb_wr_data),
        .xfer_done(xfer_done), .apb_rd_data_out(apb_rd_data_out),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Advance to the middle of the next cycle; inputs set after this apply to
    // that cycle and the following rising edge.
    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        PRST = 1'b0;
        req_valid = 2'b01;
        step(); step(); settle();
        total_cnt++;
        if (req_ack !== 2'b00)
            $display("FAIL reset_ack: got %b required 00", req_ack);
        else pass_cnt++;
        total_cnt++;
        if ({transfer, RD_WR, apb_wr_padd, apb_rd_padd, apb_wr_data, resp_valid, resp_rdata, resp_err, resp_timeout} !== 40'd0)
            $display("FAIL reset_outputs: got %h required 0", {transfer, RD_WR, apb_wr_padd, apb_rd_padd, apb_wr_data, resp_valid, resp_rdata, resp_err, resp_timeout});
        else pass_cnt++;
        step();
        PRST = 1'b1;
        req_valid = 2'b00;
        settle();
        total_cnt++;
        if ({req_ack, transfer, resp_valid} !== 5'd0)
            $display("FAIL reset_release_idle: got %b required 00000", {req_ack, transfer, resp_valid});
        else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_write();
        step();
        req_valid = 2'b01; req_write = 2'b01;
        req_addr = 18'h00005; req_wdata = 16'h00A5;
        settle();
        total_cnt++;
        if ({req_ack, transfer} !== 3'b010)
            $display("FAIL wr_ack: got ack=%b transfer=%b required ack=01 transfer=0", req_ack, transfer);
        else pass_cnt++;
        for (int c = 1; c <= 3; c++) begin
            step();
            req_valid = 2'b00;
            xfer_done = (c == 3);
            settle();
            total_cnt++;
            if ({transfer, RD_WR, apb_wr_padd, apb_wr_data, apb_rd_padd, req_ack, resp_valid} !== {1'b1, 1'b0, 9'h005, 8'hA5, 9'h000, 2'b00, 2'b00})
                $display("FAIL wr_busy_c%0d: got tr=%b rw=%b wpa=%h wd=%h rpa=%h ack=%b rv=%b required tr=1 rw=0 wpa=005 wd=a5 rpa=000 ack=00 rv=00",
                         c, transfer, RD_WR, apb_wr_padd, apb_wr_data, apb_rd_padd, req_ack, resp_valid);
            else pass_cnt++;
        end
        step();
        xfer_done = 1'b0;
        settle();
        total_cnt++;
        if ({resp_valid, resp_err, resp_timeout, resp_rdata, transfer} !== {2'b01, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL wr_resp: got rv=%b err=%b to=%b rd=%h tr=%b required rv=01 err=0 to=0 rd=00 tr=0",
                     resp_valid, resp_err, resp_timeout, resp_rdata, transfer);
        else pass_cnt++;
        step(); settle();
        total_cnt++;
        if (resp_valid !== 2'b00)
            $display("FAIL wr_resp_pulse: got %b required 00", resp_valid);
        else pass_cnt++;
        $display("write req0 addr=005 data=a5 completed");
    endtask

    task automatic test_read();
        req_valid = 2'b10; req_write = 2'b00;
        req_addr = {9'h105, 9'h000}; req_wdata = 16'h0000;
        settle();
        total_cnt++;
        if (req_ack !== 2'b10)
            $display("FAIL rd_ack: got %b required 10", req_ack);
        else pass_cnt++;
        step();
        req_valid = 2'b00;
        xfer_done = 1'b1; apb_rd_data_out = 8'h3C;
        settle();
        total_cnt++;
        if ({transfer, RD_WR, apb_rd_padd, apb_wr_padd, apb_wr_data} !== {1'b1, 1'b1, 9'h105, 9'h000, 8'h00})
            $display("FAIL rd_busy: got tr=%b rw=%b rpa=%h wpa=%h wd=%h required tr=1 rw=1 rpa=105 wpa=000 wd=00",
                     transfer, RD_WR, apb_rd_padd, apb_wr_padd, apb_wr_data);
        else pass_cnt++;
        step();
        xfer_done = 1'b0; apb_rd_data_out = 8'hFF;
        settle();
        total_cnt++;
        if ({resp_valid, resp_rdata, resp_err, resp_timeout} !== {2'b10, 8'h3C, 1'b0, 1'b0})
            $display("FAIL rd_resp: got rv=%b rd=%h err=%b to=%b required rv=10 rd=3c err=0 to=0",
                     resp_valid, resp_rdata, resp_err, resp_timeout);
        else pass_cnt++;
        step();
        $display("read req1 addr=105 data=3c completed");
    endtask

    // Both requesters hold valid; with done in the 2nd BUSY cycle (n=2) acks
    // must alternate 0,1,0,1 exactly 4 cycles apart.
    task automatic test_round_robin();
        logic [1:0] exp_ack;
        req_valid = 2'b11; req_write = 2'b11;
        req_addr = {9'h0AA, 9'h055}; req_wdata = 16'h2211;
        for (int k = 0; k < 4; k++) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            total_cnt++;
            if (req_ack !== exp_ack)
                $display("FAIL rr_ack_%0d: got %b required %b", k, req_ack, exp_ack);
            else pass_cnt++;
            step(); settle();
            total_cnt++;
            if ({transfer, req_ack} !== 3'b100)
                $display("FAIL rr_busy_%0d: got tr=%b ack=%b required tr=1 ack=00", k, transfer, req_ack);
            else pass_cnt++;
            step();
            xfer_done = 1'b1;
            step();
            xfer_done = 1'b0;
            settle();
            total_cnt++;
            if ({resp_valid, req_ack} !== {exp_ack, 2'b00})
                $display("FAIL rr_resp_%0d: got rv=%b ack=%b required rv=%b ack=00", k, resp_valid, req_ack, exp_ack);
            else pass_cnt++;
            step();
            $display("round-robin grant %0d to requester %0d", k, k % 2);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_slave_error();
        req_valid = 2'b01; req_write = 2'b00;
        req_addr = 18'h00033;
        settle();
        total_cnt++;
        if (req_ack !== 2'b01)
            $display("FAIL err_ack: got %b required 01", req_ack);
        else pass_cnt++;
        step();
        req_valid = 2'b00;
        step();
        PSLVERR = 1'b1; xfer_done = 1'b1; apb_rd_data_out = 8'h77;
        step();
        PSLVERR = 1'b0; xfer_done = 1'b0;
        settle();
        total_cnt++;
        if ({resp_valid, resp_err, resp_timeout, resp_rdata} !== {2'b01, 1'b1, 1'b0, 8'h00})
            $display("FAIL err_resp: got rv=%b err=%b to=%b rd=%h required rv=01 err=1 to=0 rd=00",
                     resp_valid, resp_err, resp_timeout, resp_rdata);
        else pass_cnt++;
        step();
        $display("slave error on req0 read reported");
    endtask

    task automatic test_timeout();
        int cnt;
        req_valid = 2'b10; req_write = 2'b10;
        req_addr = {9'h1F0, 9'h000}; req_wdata = 16'h5500;
        settle();
        total_cnt++;
        if (req_ack !== 2'b10)
            $display("FAIL to_ack: got %b required 10", req_ack);
        else pass_cnt++;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            req_valid = 2'b00;
            settle();
            if (transfer === 1'b1) cnt++;
            else break;
        end
        total_cnt++;
        if (cnt !== 16)
            $display("FAIL to_busy_len: got %0d cycles required 16", cnt);
        else pass_cnt++;
        total_cnt++;
        if ({resp_valid, resp_err, resp_timeout, resp_rdata} !== {2'b10, 1'b1, 1'b1, 8'h00})
            $display("FAIL to_resp: got rv=%b err=%b to=%b rd=%h required rv=10 err=1 to=1 rd=00",
                     resp_valid, resp_err, resp_timeout, resp_rdata);
        else pass_cnt++;
        step();
        $display("timeout on req1 write after %0d busy cycles", cnt);
    endtask

    // Completion in the last BUSY cycle before timeout must win.
    task automatic test_done_at_limit();
        req_valid = 2'b01; req_write = 2'b00;
        req_addr = 18'h00144;
        settle();
        total_cnt++;
        if (req_ack !== 2'b01)
            $display("FAIL lim_ack: got %b required 01", req_ack);
        else pass_cnt++;
        for (int c = 1; c <= 16; c++) begin
            step();
            req_valid = 2'b00;
            xfer_done = (c == 16);
            apb_rd_data_out = (c == 16) ? 8'h5A : 8'h00;
        end
        step();
        xfer_done = 1'b0;
        settle();
        total_cnt++;
        if ({resp_valid, resp_err, resp_timeout, resp_rdata} !== {2'b01, 1'b0, 1'b0, 8'h5A})
            $display("FAIL lim_resp: got rv=%b err=%b to=%b rd=%h required rv=01 err=0 to=0 rd=5a",
                     resp_valid, resp_err, resp_timeout, resp_rdata);
        else pass_cnt++;
        step();
        $display("done at timeout limit on req0 read data=5a");
    endtask

    task automatic test_reset_mid_busy();
        req_valid = 2'b01; req_write = 2'b01;
        req_addr = 18'h00011; req_wdata = 16'h00C3;
        settle();
        total_cnt++;
        if (req_ack !== 2'b01)
            $display("FAIL mid_ack: got %b required 01", req_ack);
        else pass_cnt++;
        step();
        req_valid = 2'b00;
        PRST = 1'b0;
        step();
        PRST = 1'b1;
        xfer_done = 1'b1;
        settle();
        total_cnt++;
        if ({transfer, RD_WR, apb_wr_padd, apb_rd_padd, apb_wr_data, resp_valid, resp_rdata, resp_err, resp_timeout, req_ack} !== 42'd0)
            $display("FAIL mid_outputs: got %h required 0",
                     {transfer, RD_WR, apb_wr_padd, apb_rd_padd, apb_wr_data, resp_valid, resp_rdata, resp_err, resp_timeout, req_ack});
        else pass_cnt++;
        step();
        xfer_done = 1'b0;
        settle();
        total_cnt++;
        if ({resp_valid, transfer} !== 3'b000)
            $display("FAIL mid_no_resp: got rv=%b tr=%b required rv=00 tr=0", resp_valid, transfer);
        else pass_cnt++;
        step();
        req_valid = 2'b11; req_write = 2'b00;
        settle();
        total_cnt++;
        if (req_ack !== 2'b01)
            $display("FAIL mid_ptr_reset: got %b required 01", req_ack);
        else pass_cnt++;
        step();
        req_valid = 2'b00;
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        settle();
        total_cnt++;
        if (resp_valid !== 2'b01)
            $display("FAIL mid_recover_resp: got %b required 01", resp_valid);
        else pass_cnt++;
        step();
        $display("reset mid-busy dropped command, next request served");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_slave_error();
        test_timeout();
        test_done_at_limit();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares one APB master between two requesters. It accepts one read or write command at a time, latches it, and drives the master's transfer/command inputs until the access completes, errors or times out. It then returns a one-cycle response to the winning requester. It sits directly in front of `apb_master`, whose ports it drives.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles before abort; legal range 2..255.
- `PCLK`  in  1  clock; all logic on rising edge.
- `PRST`  in  1  reset, synchronous, active-low.
- `req_valid`  in  2  bit i = requester i has a command pending; held until `req_ack[i]`.
- `req_write`  in  2  bit i: 1 = write, 0 = read.
- `req_addr`  in  18  requester i address in bits [9i+8:9i]; addr[8] selects slave 2.
- `req_wdata`  in  16  requester i write data in bits [8i+7:8i].
- `req_ack`  out  2  one-hot, one-cycle pulse: command accepted and latched.
- `resp_valid`  out  2  one-hot, one-cycle pulse: response for requester i.
- `resp_rdata`  out  8  read data; valid only with `resp_valid`.
- `resp_err`  out  1  slave error or timeout; valid only with `resp_valid`.
- `resp_timeout`  out  1  the abort was a timeout; valid only with `resp_valid`.
- `transfer`  out  1  to master: transfer request.
- `RD_WR`  out  1  to master: 1 = read, 0 = write.
- `apb_wr_padd`  out  9  to master: write address.
- `apb_rd_padd`  out  9  to master: read address.
- `apb_wr_data`  out  8  to master: write data.
- `xfer_done`  in  1  one-cycle pulse: access phase completed (PREADY sampled high in enable).
- `apb_rd_data_out`  in  8  from master: read data; valid in the `xfer_done` cycle.
- `PSLVERR`  in  1  from master: error flag.

## Operation
- States:
  - IDLE (00): waiting for a request.
  - BUSY (01): command active on the master.
  - RESP (10): response cycle.
  - 11 is unreachable and decodes to IDLE.
- `rr_ptr` is a 1-bit priority pointer.
  - If `req_valid[rr_ptr]` is set, grant `rr_ptr`; otherwise grant the other requester if it is valid.
- IDLE:
  - `transfer`=0.
  - If any `req_valid` is set, assert `req_ack[g]` combinationally for the granted requester g.
  - Latch write/addr/wdata of g and record g; next state BUSY.
- BUSY:
  - `transfer`=1 and `RD_WR`=~write.
  - Read: `apb_rd_padd`=addr, `apb_wr_padd`=0, `apb_wr_data`=0.
  - Write: `apb_wr_padd`=addr, `apb_wr_data`=wdata, `apb_rd_padd`=0.
  - The 8-bit counter `tcnt` increments each BUSY cycle and clears on entry.
- BUSY exits, checked in priority order:
  1. `PSLVERR`=1: err=1, timeout=0, next state RESP.
  2. `xfer_done`=1: err=0; capture `apb_rd_data_out` into the rdata register if read, else rdata=0; next state RESP.
  3. `tcnt`==TIMEOUT-1: err=1, timeout=1, rdata=0, next state RESP.
- RESP:
  - `transfer`=0; address/data outputs hold their values.
  - `resp_valid[g]`=1 with the registered rdata/err/timeout.
  - `rr_ptr`<=~g; next state IDLE.
- `req_valid` is not sampled in BUSY or RESP; `req_ack` stays 0 there.
- The non-granted requester is served in its next IDLE cycle, so starvation is bounded to one command.

## Timing
- Reset (`PRST`=0 at an edge) values:
  - state=IDLE, `rr_ptr`=0, `tcnt`=0.
  - `transfer`, `RD_WR`, `apb_wr_padd`, `apb_rd_padd`, `apb_wr_data`, `resp_valid`, `resp_rdata`, `resp_err`, `resp_timeout` all 0.
  - `req_ack`=0 while `PRST`=0.
- Reset mid-BUSY or mid-RESP: the command is dropped, no `resp_valid` is issued, and `transfer` drops the next cycle.
- Accept at edge k (IDLE, ack high in cycle k):
  - `transfer` is high for cycles k+1..k+n, where `xfer_done` arrives in cycle k+n.
  - `resp_valid` is high in cycle k+n+1.
  - Earliest next ack is cycle k+n+2, so minimum per-command occupancy is n+2 cycles.
- `xfer_done` and `PSLVERR` in the same cycle: the error wins.
- `xfer_done` in the cycle where `tcnt`==TIMEOUT-1: the completion wins, with no timeout.
- Timeout with no done: exactly TIMEOUT BUSY cycles, then RESP.
- `xfer_done`/`PSLVERR` arriving outside BUSY: ignored.
- All outputs except `req_ack` are registered.

## Test plan
- Write, single requester:
  - Stimulus: reset, then req0 write addr 0x005 data 0xA5; `xfer_done` in the 3rd BUSY cycle.
  - Required: `req_ack`=01 in cycle 0; `transfer`=1 in cycles 1-3 with `apb_wr_padd`=0x005, `apb_wr_data`=0xA5, `RD_WR`=0; `resp_valid`=01 in cycle 4 with err=0.
- Read, requester 1:
  - Stimulus: req1 read addr 0x105; `xfer_done` in the 1st BUSY cycle with `apb_rd_data_out`=0x3C.
  - Required: `apb_rd_padd`=0x105, `RD_WR`=1; `resp_valid`=10 with `resp_rdata`=0x3C.
- Round-robin:
  - Stimulus: both requesters hold valid continuously after reset.
  - Required: grants come in the order 0,1,0,1, with each ack exactly n+2 cycles apart.
- Slave error:
  - Stimulus: `PSLVERR`=1 in the 2nd BUSY cycle, together with `xfer_done`.
  - Required: `resp_err`=1, `resp_timeout`=0, `resp_rdata`=0.
- Timeout (TIMEOUT=16):
  - Stimulus: `xfer_done` never arrives.
  - Required: `transfer` high for exactly 16 cycles, then `resp_err`=1 and `resp_timeout`=1.
- Reset mid-BUSY:
  - Stimulus: `PRST`=0 for one edge during BUSY.
  - Required: all outputs 0 on the next cycle, no `resp_valid`, `rr_ptr`=0, and a new request is acked normally afterwards.
